// File: rtl/hs_rxfifo_pkg.sv
// Shared types and constants for the hs_rxfifo receive FIS buffer.
// Holds the write-FSM encoding, drop-cause codes, FIS type codes and the stored word layout.
package hs_rxfifo_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_CRC   = 2'd1;
    localparam logic [1:0] CAUSE_ABORT = 2'd2;
    localparam logic [1:0] CAUSE_OVF   = 2'd3;

    localparam logic [7:0] FIS_REG_D2H   = 8'h34;
    localparam logic [7:0] FIS_DMA_ACT   = 8'h39;
    localparam logic [7:0] FIS_DATA      = 8'h46;
    localparam logic [7:0] FIS_PIO_SETUP = 8'h5F;

    typedef struct packed {
        logic        eof;
        logic        sof;
        logic [31:0] data;
    } rx_word_t;

    // {PM port, FIS type} taken from dword 0 of a FIS
    function automatic logic [11:0] fis_hdr(input rx_word_t w);
        return w.data[11:0];
    endfunction

endpackage

// File: rtl/hs_rxfifo_ram.sv
// Simple dual-port storage for hs_rxfifo: one write port, one registered read port.
// Read-during-write to the same address returns the old contents; the parent bypasses that case.
module hs_rxfifo_ram
    import hs_rxfifo_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  rx_word_t          wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output rx_word_t          rdata_o
);

    rx_word_t mem_q [2**ADDR_W];
    rx_word_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hs_rxfifo.sv
// Store-and-forward SATA receive FIS buffer: only CRC-good, complete FISes become readable.
// Optional HS_RXFIFO_DROP_STAT_EN adds saturating per-cause discard counters.
module hs_rxfifo
    import hs_rxfifo_pkg::*;
#(
    parameter int ADDR_W          = 9,
    parameter int ALMOST_FULL_TH  = 16,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
`ifdef HS_RXFIFO_DROP_STAT_EN
    input  logic              drop_cnt_clr,
    output logic [15:0]       drop_crc_cnt,
    output logic [15:0]       drop_abort_cnt,
    output logic [15:0]       drop_ovf_cnt,
`endif
    input  logic [31:0]       rx_data,
    input  logic              rx_wr_en,
    input  logic              rx_sof,
    input  logic              rx_eof,
    input  logic              rx_crc_ok,
    input  logic              rx_abort,
    output logic              rx_almost_full,
    output logic              rx_full,
    output logic              rx_good,
    output logic              rx_bad,
    output logic [31:0]       rxfifo_data,
    output logic              rxfifo_sof,
    output logic              rxfifo_eof,
    output logic [11:0]       rxfifo_fis_hdr,
    output logic              rxfifo_empty,
    output logic              rxfifo_almost_empty,
    output logic              rxfifo_eof_rdy,
    output logic [ADDR_W:0]   rxfifo_rd_count,
    input  logic              rxfifo_rd_en
);

    localparam int            PW      = ADDR_W + 1;
    localparam logic [PW-1:0] ONE     = PW'(1);
    localparam logic [PW-1:0] DEPTH_P = PW'(2**ADDR_W);
    localparam logic [PW-1:0] AF_TH   = PW'(ALMOST_FULL_TH);
    localparam logic [PW-1:0] AE_TH   = PW'(ALMOST_EMPTY_TH);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, start_ptr_q, start_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] eof_cnt_q, eof_cnt_d;
    logic          good_q, good_d, bad_q, bad_d;
    logic [1:0]    cause_d;
    logic          ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    rx_word_t      ram_wdata, ram_rdata, byp_q, head;
    logic          byp_vld_q;
    logic [11:0]   hdr_q;
    logic [PW-1:0] used, free, count;
    logic          full, empty, pop;

    assign used  = wr_ptr_q - rd_ptr_q;
    assign free  = DEPTH_P - used;
    assign full  = (used == DEPTH_P);
    assign count = commit_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign pop   = rxfifo_rd_en && !empty;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        start_ptr_d  = start_ptr_q;
        commit_ptr_d = commit_ptr_q;
        good_d       = 1'b0;
        bad_d        = 1'b0;
        cause_d      = CAUSE_NONE;
        ram_we       = 1'b0;
        ram_waddr    = wr_ptr_q[ADDR_W-1:0];
        ram_wdata    = '{eof: rx_eof, sof: rx_sof, data: rx_data};
        case (state_q)
            ST_RECV: begin
                if (rx_abort) begin
                    wr_ptr_d = start_ptr_q;
                    bad_d    = 1'b1;
                    cause_d  = CAUSE_ABORT;
                    state_d  = ST_IDLE;
                end else if (rx_wr_en && rx_sof) begin
                    // Restart at the rewound slot; a restart that is also eof is discarded with the prior FIS
                    bad_d     = 1'b1;
                    cause_d   = CAUSE_ABORT;
                    ram_we    = 1'b1;
                    ram_waddr = start_ptr_q[ADDR_W-1:0];
                    if (rx_eof) begin
                        wr_ptr_d = start_ptr_q;
                        state_d  = ST_IDLE;
                    end else begin
                        wr_ptr_d = start_ptr_q + ONE;
                    end
                end else if (rx_wr_en) begin
                    if (full) begin
                        if (rx_eof) begin
                            wr_ptr_d = start_ptr_q;
                            bad_d    = 1'b1;
                            cause_d  = CAUSE_OVF;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE;
                        if (rx_eof) begin
                            state_d = ST_IDLE;
                            if (rx_crc_ok) begin
                                commit_ptr_d = wr_ptr_q + ONE;
                                good_d       = 1'b1;
                            end else begin
                                wr_ptr_d = start_ptr_q;
                                bad_d    = 1'b1;
                                cause_d  = CAUSE_CRC;
                            end
                        end
                    end
                end
            end
            ST_DROP: begin
                if (rx_abort || (rx_wr_en && rx_eof)) begin
                    wr_ptr_d = start_ptr_q;
                    bad_d    = 1'b1;
                    cause_d  = CAUSE_OVF;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                if (rx_wr_en && rx_sof) begin
                    start_ptr_d = wr_ptr_q;
                    if (full) begin
                        if (rx_eof) begin
                            bad_d   = 1'b1;
                            cause_d = CAUSE_OVF;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        ram_we = 1'b1;
                        if (!rx_eof) begin
                            wr_ptr_d = wr_ptr_q + ONE;
                            state_d  = ST_RECV;
                        end else if (rx_crc_ok) begin
                            wr_ptr_d     = wr_ptr_q + ONE;
                            commit_ptr_d = wr_ptr_q + ONE;
                            good_d       = 1'b1;
                        end else begin
                            bad_d   = 1'b1;
                            cause_d = CAUSE_CRC;
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        rd_ptr_d  = pop ? (rd_ptr_q + ONE) : rd_ptr_q;
        eof_cnt_d = eof_cnt_q;
        if (good_d && !(pop && head.eof)) begin
            eof_cnt_d = eof_cnt_q + ONE;
        end else if (!good_d && pop && head.eof) begin
            eof_cnt_d = eof_cnt_q - ONE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            start_ptr_q  <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            eof_cnt_q    <= '0;
            good_q       <= 1'b0;
            bad_q        <= 1'b0;
            byp_vld_q    <= 1'b0;
            hdr_q        <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            start_ptr_q  <= start_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            eof_cnt_q    <= eof_cnt_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            byp_vld_q    <= ram_we && (ram_waddr == rd_ptr_d[ADDR_W-1:0]);
            hdr_q        <= rxfifo_fis_hdr;
        end
    end

    // Write landing on the slot being read this edge: forward it instead of the stale RAM word
    always_ff @(posedge sys_clk) begin
        byp_q <= ram_wdata;
    end

    hs_rxfifo_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk_i   (sys_clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_ptr_d[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    assign head                = byp_vld_q ? byp_q : ram_rdata;
    assign rxfifo_data         = empty ? 32'h0 : head.data;
    assign rxfifo_sof          = !empty && head.sof;
    assign rxfifo_eof          = !empty && head.eof;
    assign rxfifo_fis_hdr      = (!empty && head.sof) ? fis_hdr(head) : hdr_q;
    assign rxfifo_empty        = empty;
    assign rxfifo_almost_empty = (count <= AE_TH);
    assign rxfifo_eof_rdy      = (eof_cnt_q != '0);
    assign rxfifo_rd_count     = count;
    assign rx_full             = full;
    assign rx_almost_full      = (free <= AF_TH);
    assign rx_good             = good_q;
    assign rx_bad              = bad_q;

`ifdef HS_RXFIFO_DROP_STAT_EN
    generate
        for (genvar gi = 1; gi <= 3; gi++) begin : g_drop
            logic [15:0] cnt_q;
            always_ff @(posedge sys_clk) begin
                if (sys_rst || drop_cnt_clr) begin
                    cnt_q <= '0;
                end else if (bad_d && (cause_d == 2'(gi)) && (cnt_q != 16'hFFFF)) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    endgenerate

    assign drop_crc_cnt   = g_drop[1].cnt_q;
    assign drop_abort_cnt = g_drop[2].cnt_q;
    assign drop_ovf_cnt   = g_drop[3].cnt_q;
`else
    logic unused_cause;
    assign unused_cause = ^cause_d;
`endif

endmodule

// File: tb/tb_hs_rxfifo.sv
// Self-checking bench for hs_rxfifo: a vector table for one full FIS round trip,
// then directed sequences for CRC failure, overflow, abort, restart, wrap and reset.
module tb_hs_rxfifo;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] rx_data;
    logic        rx_wr_en, rx_sof, rx_eof, rx_crc_ok, rx_abort;
    logic        rx_almost_full, rx_full, rx_good, rx_bad;
    logic [31:0] rxfifo_data;
    logic        rxfifo_sof, rxfifo_eof;
    logic [11:0] rxfifo_fis_hdr;
    logic        rxfifo_empty, rxfifo_almost_empty, rxfifo_eof_rdy;
    logic [9:0]  rxfifo_rd_count;
    logic        rxfifo_rd_en;
`ifdef HS_RXFIFO_DROP_STAT_EN
    logic        drop_cnt_clr = 1'b0;
    logic [15:0] drop_crc_cnt, drop_abort_cnt, drop_ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    hs_rxfifo dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
`ifdef HS_RXFIFO_DROP_STAT_EN
        .drop_cnt_clr        (drop_cnt_clr),
        .drop_crc_cnt        (drop_crc_cnt),
        .drop_abort_cnt      (drop_abort_cnt),
        .drop_ovf_cnt        (drop_ovf_cnt),
`endif
        .rx_data             (rx_data),
        .rx_wr_en            (rx_wr_en),
        .rx_sof              (rx_sof),
        .rx_eof              (rx_eof),
        .rx_crc_ok           (rx_crc_ok),
        .rx_abort            (rx_abort),
        .rx_almost_full      (rx_almost_full),
        .rx_full             (rx_full),
        .rx_good             (rx_good),
        .rx_bad              (rx_bad),
        .rxfifo_data         (rxfifo_data),
        .rxfifo_sof          (rxfifo_sof),
        .rxfifo_eof          (rxfifo_eof),
        .rxfifo_fis_hdr      (rxfifo_fis_hdr),
        .rxfifo_empty        (rxfifo_empty),
        .rxfifo_almost_empty (rxfifo_almost_empty),
        .rxfifo_eof_rdy      (rxfifo_eof_rdy),
        .rxfifo_rd_count     (rxfifo_rd_count),
        .rxfifo_rd_en        (rxfifo_rd_en)
    );

    typedef struct {
        logic        wr, sof, eof, crc, rd;
        logic [31:0] d;
        logic        e_good;
        logic [9:0]  e_cnt;
        logic        e_empty, e_eofrdy, e_aempty;
        logic [31:0] e_data;
        logic [11:0] e_hdr;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One clock with the given inputs, then sample 1 time unit after the edge
    task automatic cyc(input logic wr, input logic sof, input logic eof, input logic crc,
                       input logic rd, input logic abt, input logic [31:0] d);
        rx_wr_en = wr; rx_sof = sof; rx_eof = eof; rx_crc_ok = crc;
        rxfifo_rd_en = rd; rx_abort = abt; rx_data = d;
        @(posedge sys_clk);
        #1;
        rx_wr_en = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_crc_ok = 1'b0;
        rxfifo_rd_en = 1'b0; rx_abort = 1'b0; rx_data = 32'h0;
    endtask

    function automatic logic [31:0] dw(input int i);
        return (i == 0) ? 32'h0000_0346 : (32'hA000_0000 | 32'(i));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int tb_addr;
        int flen;
        sys_rst = 1'b1;
        rx_wr_en = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_crc_ok = 1'b0;
        rx_abort = 1'b0; rxfifo_rd_en = 1'b0; rx_data = 32'h0;
        @(posedge sys_clk); @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        $display("reset state");
        chk("rst_empty",  rxfifo_empty, 1);
        chk("rst_aempty", rxfifo_almost_empty, 1);
        chk("rst_eofrdy", rxfifo_eof_rdy, 0);
        chk("rst_count",  rxfifo_rd_count, 0);
        chk("rst_full",   rx_full, 0);
        chk("rst_afull",  rx_almost_full, 0);
        chk("rst_good",   rx_good, 0);
        chk("rst_bad",    rx_bad, 0);
        chk("rst_sof",    rxfifo_sof, 0);
        chk("rst_eof",    rxfifo_eof, 0);
        chk("rst_data",   rxfifo_data, 0);
        chk("rst_hdr",    rxfifo_fis_hdr, 0);

        // 7-dword DATA FIS from PM port 3, then seven pops
        for (int i = 0; i < 14; i++) begin
            if (i < 7) begin
                vt[i] = '{wr: 1'b1, sof: (i == 0), eof: (i == 6), crc: 1'b1, rd: 1'b0, d: dw(i),
                          e_good: (i == 6), e_cnt: (i == 6) ? 10'd7 : 10'd0,
                          e_empty: (i != 6), e_eofrdy: (i == 6), e_aempty: (i != 6),
                          e_data: (i == 6) ? dw(0) : 32'h0, e_hdr: (i == 6) ? 12'h346 : 12'h0};
            end else begin
                vt[i] = '{wr: 1'b0, sof: 1'b0, eof: 1'b0, crc: 1'b0, rd: 1'b1, d: 32'h0,
                          e_good: 1'b0, e_cnt: 10'(13 - i),
                          e_empty: (i == 13), e_eofrdy: (i != 13), e_aempty: ((13 - i) <= 2),
                          e_data: (i == 13) ? 32'h0 : dw(i - 6), e_hdr: 12'h346};
            end
        end
        for (int i = 0; i < 14; i++) begin
            cyc(vt[i].wr, vt[i].sof, vt[i].eof, vt[i].crc, vt[i].rd, 1'b0, vt[i].d);
            $display("vec %0d wr=%0b rd=%0b cnt=%0d data=%h", i, vt[i].wr, vt[i].rd,
                     rxfifo_rd_count, rxfifo_data);
            chk($sformatf("v%0d_good", i),   rx_good, vt[i].e_good);
            chk($sformatf("v%0d_bad", i),    rx_bad, 0);
            chk($sformatf("v%0d_cnt", i),    rxfifo_rd_count, vt[i].e_cnt);
            chk($sformatf("v%0d_empty", i),  rxfifo_empty, vt[i].e_empty);
            chk($sformatf("v%0d_eofrdy", i), rxfifo_eof_rdy, vt[i].e_eofrdy);
            chk($sformatf("v%0d_aempty", i), rxfifo_almost_empty, vt[i].e_aempty);
            chk($sformatf("v%0d_data", i),   rxfifo_data, vt[i].e_data);
            chk($sformatf("v%0d_hdr", i),    rxfifo_fis_hdr, vt[i].e_hdr);
        end
        tb_addr = 7;

        // CRC failure, then a good 3-dword FIS
        $display("crc fail then good fis");
        for (int i = 0; i < 5; i++) cyc(1, i == 0, i == 4, 0, 0, 0, 32'hBAD0_0000 | 32'(i));
        chk("crc_bad", rx_bad, 1);
        chk("crc_good", rx_good, 0);
        chk("crc_cnt", rxfifo_rd_count, 0);
        chk("crc_empty", rxfifo_empty, 1);
        for (int i = 0; i < 3; i++) cyc(1, i == 0, i == 2, 1, 0, 0, 32'hB000_0034 + 32'(i));
        chk("g3_good", rx_good, 1);
        chk("g3_bad", rx_bad, 0);
        chk("g3_cnt", rxfifo_rd_count, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("g3_data%0d", i), rxfifo_data, 32'hB000_0034 + 32'(i));
            chk($sformatf("g3_eof%0d", i), rxfifo_eof, (i == 2));
            cyc(0, 0, 0, 0, 1, 0, 0);
        end
        chk("g3_empty", rxfifo_empty, 1);
        tb_addr += 3;

        // 510 committed dwords, then an overflowing 5-dword FIS
        $display("fill and overflow");
        for (int i = 0; i < 510; i++) cyc(1, (i % 51) == 0, (i % 51) == 50, 1, 0, 0, 32'h1000_0000 + 32'(i));
        chk("fill_cnt", rxfifo_rd_count, 510);
        chk("fill_afull", rx_almost_full, 1);
        chk("fill_full", rx_full, 0);
        cyc(1, 1, 0, 1, 0, 0, 32'hD000_0000);
        chk("ovf_full1", rx_full, 0);
        cyc(1, 0, 0, 1, 0, 0, 32'hD000_0001);
        chk("ovf_full2", rx_full, 1);
        cyc(1, 0, 0, 1, 0, 0, 32'hD000_0002);
        chk("ovf_drop_bad", rx_bad, 0);
        chk("ovf_drop_full", rx_full, 1);
        cyc(1, 0, 0, 1, 0, 0, 32'hD000_0003);
        cyc(1, 0, 1, 1, 0, 0, 32'hD000_0004);
        chk("ovf_bad", rx_bad, 1);
        chk("ovf_good", rx_good, 0);
        chk("ovf_cnt", rxfifo_rd_count, 510);
        chk("ovf_rewound", rx_full, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("ovf_bad_pulse", rx_bad, 0);
        for (int i = 0; i < 510; i++) begin
            chk("drain_data", rxfifo_data, 32'h1000_0000 + 32'(i));
            cyc(0, 0, 0, 0, 1, 0, 0);
        end
        chk("drain_empty", rxfifo_empty, 1);
        chk("drain_eofrdy", rxfifo_eof_rdy, 0);
        tb_addr = (tb_addr + 510) % 512;

        // Abort after 4 dwords, then a clean FIS
        $display("abort then good fis");
        for (int i = 0; i < 4; i++) cyc(1, i == 0, 0, 0, 0, 0, 32'hEE00_0000 | 32'(i));
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("abt_bad", rx_bad, 1);
        chk("abt_empty", rxfifo_empty, 1);
        for (int i = 0; i < 3; i++) cyc(1, i == 0, i == 2, 1, 0, 0, 32'hC000_005F + 32'(i));
        chk("abt_good", rx_good, 1);
        chk("abt_cnt", rxfifo_rd_count, 3);
        chk("abt_hdr", rxfifo_fis_hdr, 12'h05F);
        for (int i = 0; i < 3; i++) begin
            chk("abt_data", rxfifo_data, 32'hC000_005F + 32'(i));
            cyc(0, 0, 0, 0, 1, 0, 0);
        end
        chk("abt_empty2", rxfifo_empty, 1);
        tb_addr = (tb_addr + 3) % 512;

        // Second SOF inside a FIS restarts it
        $display("restart on sof");
        cyc(1, 1, 0, 1, 0, 0, 32'hE100_0000);
        cyc(1, 0, 0, 1, 0, 0, 32'hE100_0001);
        cyc(1, 1, 0, 1, 0, 0, 32'hF000_0134);
        chk("rs_bad", rx_bad, 1);
        cyc(1, 0, 1, 1, 0, 0, 32'hF000_0001);
        chk("rs_good", rx_good, 1);
        chk("rs_cnt", rxfifo_rd_count, 2);
        chk("rs_data0", rxfifo_data, 32'hF000_0134);
        chk("rs_sof0", rxfifo_sof, 1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("rs_data1", rxfifo_data, 32'hF000_0001);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("rs_empty", rxfifo_empty, 1);
        tb_addr = (tb_addr + 2) % 512;

        // Filler ends at slot 511; last pop coincides with a 1-dword commit at slot 0
        $display("wrap with simultaneous commit and pop");
        flen = 512 - tb_addr;
        for (int i = 0; i < flen; i++) cyc(1, i == 0, i == flen - 1, 1, 0, 0, 32'h2000_0000 + 32'(i));
        for (int i = 0; i < flen - 1; i++) begin
            chk("fill2_data", rxfifo_data, 32'h2000_0000 + 32'(i));
            cyc(0, 0, 0, 0, 1, 0, 0);
        end
        chk("wrap_pre_cnt", rxfifo_rd_count, 1);
        chk("wrap_pre_eof", rxfifo_eof, 1);
        chk("wrap_pre_data", rxfifo_data, 32'h2000_0000 + 32'(flen - 1));
        cyc(1, 1, 1, 1, 1, 0, 32'h5A5A_0039);
        chk("wrap_good", rx_good, 1);
        chk("wrap_cnt", rxfifo_rd_count, 1);
        chk("wrap_eofrdy", rxfifo_eof_rdy, 1);
        chk("wrap_data", rxfifo_data, 32'h5A5A_0039);
        chk("wrap_sofeof", {rxfifo_sof, rxfifo_eof}, 2'b11);
        chk("wrap_hdr", rxfifo_fis_hdr, 12'h039);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("wrap_empty", rxfifo_empty, 1);
        chk("wrap_eofrdy0", rxfifo_eof_rdy, 0);

        // Reset during RECV, on the cycle that would otherwise commit
        $display("reset mid-fis");
        for (int i = 0; i < 3; i++) cyc(1, i == 0, i == 2, 1, 0, 0, 32'h3300_0034 + 32'(i));
        chk("pre_rst_cnt", rxfifo_rd_count, 3);
        cyc(1, 1, 0, 1, 0, 0, 32'h4400_0046);
        cyc(1, 0, 0, 1, 0, 0, 32'h4400_0001);
        sys_rst = 1'b1;
        cyc(1, 0, 1, 1, 0, 0, 32'h4400_0002);
        sys_rst = 1'b0;
        chk("mr_empty", rxfifo_empty, 1);
        chk("mr_cnt", rxfifo_rd_count, 0);
        chk("mr_good", rx_good, 0);
        chk("mr_bad", rx_bad, 0);
        chk("mr_eofrdy", rxfifo_eof_rdy, 0);
        chk("mr_hdr", rxfifo_fis_hdr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs_rxfifo.md
Name: hs_rxfifo

Overview:
- Store-and-forward receive FIS buffer between the SATA link-layer receive path and hs_dma.
- Link side writes dwords framed by SOF/EOF with a CRC verdict.
- Complete good FISes are committed and exposed on the rxfifo_* read interface that hs_dma consumes.
- Bad, aborted or overflowed FISes are rewound and never become visible to the reader.

Parameters:
ADDR_W, 9, log2 of depth; DEPTH = 2**ADDR_W dwords (512); count ports are ADDR_W+1 bits.
ALMOST_FULL_TH, 16, rx_almost_full asserts when free space (vs speculative write pointer) <= this value.
ALMOST_EMPTY_TH, 2, rxfifo_almost_empty asserts when committed count <= this value.

Ports:
sys_clk  in  1  sole clock.
sys_rst  in  1  synchronous reset, active-high.
rx_data  in  32  link receive dword.
rx_wr_en  in  1  write strobe for rx_data.
rx_sof  in  1  qualifies rx_data as first dword of a FIS.
rx_eof  in  1  qualifies rx_data as last dword of a FIS.
rx_crc_ok  in  1  CRC verdict; sampled only with rx_wr_en & rx_eof.
rx_abort  in  1  link aborted the current FIS (SYNC escape).
rx_almost_full  out  1  threshold flag to the link layer for HOLD generation.
rx_full  out  1  no free entry.
rx_good  out  1  one-cycle pulse: FIS committed (link sends R_OK).
rx_bad  out  1  one-cycle pulse: FIS discarded (link sends R_ERR).
rxfifo_data  out  32  head dword, first-word-fall-through.
rxfifo_sof  out  1  head dword is a SOF.
rxfifo_eof  out  1  head dword is an EOF.
rxfifo_fis_hdr  out  12  {dword0[11:8] PM port, dword0[7:0] FIS type} of the FIS at the head.
rxfifo_empty  out  1  committed count == 0.
rxfifo_almost_empty  out  1  committed count <= ALMOST_EMPTY_TH.
rxfifo_eof_rdy  out  1  at least one complete committed FIS is pending.
rxfifo_rd_count  out  10  committed dwords available.
rxfifo_rd_en  in  1  pop the head dword.

Behaviour:
- Reset:
  - All pointers, counts and FSM cleared; FSM returns to IDLE.
  - Outputs after reset: rxfifo_empty=1, rxfifo_almost_empty=1, rxfifo_eof_rdy=0, rxfifo_rd_count=0, rx_full=0, rx_almost_full=0, rx_good=0, rx_bad=0, rxfifo_sof=0, rxfifo_eof=0, rxfifo_data=0, rxfifo_fis_hdr=0.
  - Reset mid-FIS discards all content.
- Storage: DEPTH x 34 bits {eof, sof, data}.
  - wr_ptr is speculative; commit_ptr is visible to the reader; start_ptr marks the start of the current FIS.
  - All three wrap modulo DEPTH.
- Write FSM states:
  - IDLE: rx_wr_en & rx_sof -> start_ptr <= wr_ptr, write dword, go RECV. Writes without sof are ignored.
  - RECV: each rx_wr_en writes and advances wr_ptr.
    - eof & crc_ok -> commit_ptr <= wr_ptr+1, pulse rx_good, go IDLE.
    - eof & !crc_ok -> wr_ptr <= start_ptr, pulse rx_bad, go IDLE.
    - rx_abort -> rewind, pulse rx_bad, go IDLE.
    - rx_sof received again -> rewind the prior FIS (rx_bad) and restart it at the current dword in the same cycle.
    - Write while rx_full -> dword dropped, go DROP.
    - Single-dword FIS (sof & eof together): write and commit or rewind in the same cycle; FSM stays IDLE.
  - DROP: ignore data until eof or rx_abort, then rewind, pulse rx_bad, go IDLE.
- Pulses: rx_good and rx_bad are registered, asserted the cycle after the terminating write, and mutually exclusive.
- Read side:
  - Head registers are valid whenever !rxfifo_empty.
  - rxfifo_rd_en & !empty -> next dword is presented on the following cycle.
  - rxfifo_rd_en on empty is ignored.
  - fis_hdr loads from head when the head has sof, and holds until the next SOF reaches the head.
- Counts and flags:
  - rxfifo_rd_count = commit_ptr - rd_ptr (ADDR_W+1 bits, full case = DEPTH).
  - A simultaneous commit and pop updates the count by (commit_len - 1) in one cycle.
  - rxfifo_eof_rdy tracks committed EOFs: increment on commit, decrement on popping an eof dword.
  - rx_full: wr_ptr - rd_ptr == DEPTH. Free space for full/almost-full is computed against rd_ptr, so pops in the cycle free space the next cycle.
- Latency: commit to !rxfifo_empty is 1 cycle.

Optional Feature:
HS_RXFIFO_DROP_STAT_EN:
- Defined: adds outputs drop_crc_cnt[15:0], drop_abort_cnt[15:0] and drop_ovf_cnt[15:0].
  - Each increments on the matching rx_bad cause, saturates at 16'hFFFF, and clears on sys_rst or drop_cnt_clr (in, 1).
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hs_rxfifo_pkg: FSM state encoding (IDLE/RECV/DROP), drop-cause encoding, FIS type constants (REG_D2H 8'h34, DMA_ACT 8'h39, DATA 8'h46, PIO_SETUP 8'h5F).
- One sub-module, hs_rxfifo_ram: simple dual-port DEPTH x 34 RAM with a registered read port; the FWFT head stage stays in the parent.

Test Plan:
- 7-dword FIS (type 8'h46, PM 4'h3), crc_ok=1 -> rx_good 1 cycle after eof; rd_count=7; fis_hdr=12'h346; eof_rdy=1; pop 7 -> empty=1, eof_rdy=0.
- 5-dword FIS with crc_ok=0 -> rx_bad pulse; rd_count stays 0; the next good 3-dword FIS reads back exactly its 3 dwords.
- Fill 510 committed dwords, then a 5-dword FIS -> rx_full after 2 dwords; FSM in DROP; rx_bad at eof; rd_count=510; wr_ptr restored.
- rx_abort after 4 dwords, then a new sof -> rx_bad; the new FIS commits normally; no stale dwords reach the reader.
- Commit a 1-dword FIS (sof&eof) while popping the last dword of the previous FIS in the same cycle -> rd_count 1->1; eof_rdy stays 1; wrap across pointer 511->0 reads correctly.
- sys_rst asserted mid-RECV with 3 committed dwords -> next cycle empty=1, rd_count=0, rx_good=rx_bad=0.
